xor4_carry_sched: RTL and testbench

//  Sequencer/arbiter that time-shares one 4-bit conditional-XOR unit (C = A ^ {4{S}}) between two requesters.

---
 rtl/xor4_carry_sched_if.sv | 35 +++
 rtl/xor4_carry_sched.sv | 133 +++++++++++++
 tb/tb_xor4_carry_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor4_carry_sched_if.sv
// Request/result handshake bundle for xor4_carry_sched: two operand requesters and one result port.
// The slave modport is the scheduler side; master is the requester/consumer side.
interface xor4_carry_sched_if #(
   parameter int WORD_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [WORD_W-1:0] req0_data;
   logic              req0_inv;
   logic              req1_valid;
   logic              req1_ready;
   logic [WORD_W-1:0] req1_data;
   logic              req1_inv;
   logic              res_valid;
   logic              res_ready;
   logic [WORD_W-1:0] res_data;
   logic              res_id;
   logic              res_parity;

   modport slave (
      input  req0_valid, req0_data, req0_inv,
      input  req1_valid, req1_data, req1_inv,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_data, res_id, res_parity
   );

   modport master (
      output req0_valid, req0_data, req0_inv,
      output req1_valid, req1_data, req1_inv,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_data, res_id, res_parity
   );
endinterface

// File: rtl/xor4_carry_sched.sv
// Time-shares one 4-bit conditional-XOR unit between two requesters, one nibble per cycle.
// Optional result parity is enabled by defining XOR4_CARRY_SCHED_PARITY_EN.
module xor4_carry_sched #(
   parameter int WORD_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   xor4_carry_sched_if.slave   bus,
   output logic [3:0]          xu_a,
   output logic                xu_s,
   input  logic [3:0]          xu_c
);
   localparam int NIB   = WORD_W / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              prio_q, prio_d;
   logic              id_q, id_d;
   logic              inv_q, inv_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [WORD_W-1:0] res_data_q, res_data_d;
   logic              grant;
   logic              accept;
   logic              idx_last;
   logic [IDX_W+1:0]  base;
   logic              par_q;

   // prio_q names the requester that wins a tie; otherwise whoever is valid wins.
   always_comb begin
      if (bus.req0_valid && bus.req1_valid) begin
         grant = prio_q;
      end else begin
         grant = bus.req1_valid;
      end
      accept   = (state_q == S_IDLE) && (grant ? bus.req1_valid : bus.req0_valid);
      idx_last = (idx_q == IDX_W'(NIB - 1));
      base     = {idx_q, 2'b00};
   end

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      prio_d         = prio_q;
      id_d           = id_q;
      inv_d          = inv_q;
      word_d         = word_q;
      res_data_d     = res_data_q;
      xu_a           = 4'h0;
      xu_s           = 1'b0;
      bus.req0_ready = (state_q == S_IDLE) && !grant;
      bus.req1_ready = (state_q == S_IDLE) && grant;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               word_d  = grant ? bus.req1_data : bus.req0_data;
               inv_d   = grant ? bus.req1_inv  : bus.req0_inv;
               id_d    = grant;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            xu_a = word_q[base +: 4];
            xu_s = inv_q;
            res_data_d[base +: 4] = xu_c;
            idx_d = idx_q + 1'b1;
            if (idx_last) begin
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
               prio_d  = ~id_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         prio_q     <= 1'b0;
         id_q       <= 1'b0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         prio_q     <= prio_d;
         id_q       <= id_d;
         res_data_q <= res_data_d;
      end
   end

   // Operand holding registers need no reset: they are always loaded before use.
   always_ff @(posedge clk) begin
      word_q <= word_d;
      inv_q  <= inv_d;
   end

`ifdef XOR4_CARRY_SCHED_PARITY_EN
   logic par_d;

   // Parity is taken from the fully assembled word on the way into DONE.
   always_comb begin
      par_d = par_q;
      if (state_q == S_RUN && idx_last) begin
         par_d = ^res_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`else
   assign par_q = 1'b0;
`endif

   assign bus.res_valid  = (state_q == S_DONE);
   assign bus.res_data   = res_data_q;
   assign bus.res_id     = id_q;
   assign bus.res_parity = par_q;
endmodule

// File: tb/tb_xor4_carry_sched.sv
// Self-checking bench for xor4_carry_sched: vector table, scoreboard, and directed corner sequences.
module tb_xor4_carry_sched;
   localparam int WORD_W = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] xu_a;
   logic [3:0] xu_c;
   logic       xu_s;

   always #5 clk = ~clk;

   xor4_carry_sched_if #(.WORD_W(WORD_W)) bus ();

   // Behavioural model of the shared nibble unit.
   assign xu_c = xu_a ^ {4{xu_s}};

   xor4_carry_sched #(.WORD_W(WORD_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .xu_a (xu_a),
      .xu_s (xu_s),
      .xu_c (xu_c)
   );

   int chk_cnt = 0;
   int pass_cnt = 0;
   int two_ready_cnt = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        id;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        inv;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic exp_par(input logic [31:0] d);
`ifdef XOR4_CARRY_SCHED_PARITY_EN
      return ^d;
`else
      return 1'b0;
`endif
   endfunction

   // Scoreboard: push on accepted request, pop on result handshake.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else begin
         if (bus.req0_ready && bus.req1_ready) two_ready_cnt++;
         if (bus.req0_valid && bus.req0_ready)
            sb_q.push_back(exp_t'{bus.req0_data ^ {32{bus.req0_inv}}, 1'b0});
         if (bus.req1_valid && bus.req1_ready)
            sb_q.push_back(exp_t'{bus.req1_data ^ {32{bus.req1_inv}}, 1'b1});
         if (bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL sb_unexpected: got result %h id %0d, required no result", bus.res_data, bus.res_id);
            end else begin
               sb_e = sb_q.pop_front();
               check("sb_data", bus.res_data, sb_e.data);
               check("sb_id", {31'd0, bus.res_id}, {31'd0, sb_e.id});
               check("sb_parity", {31'd0, bus.res_parity}, {31'd0, exp_par(sb_e.data)});
            end
         end
      end
   end

   task automatic drive_req(input logic id, input logic v, input logic [31:0] data, input logic inv);
      if (id) begin
         bus.req1_valid = v; bus.req1_data = data; bus.req1_inv = inv;
      end else begin
         bus.req0_valid = v; bus.req0_data = data; bus.req0_inv = inv;
      end
   endtask

   // Returns with the accept edge just passed (or ok=0 on timeout).
   task automatic wait_accept(input logic id, input string tag, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         ok = id ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);
      end
      if (!ok) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_op(input logic id, input logic [31:0] data, input logic inv,
                        input logic [31:0] exp_data, input string tag);
      bit ok;
      int lat;
      int bad_a;
      int bad_s;
      logic [31:0] nib;
      @(posedge clk); #1;
      drive_req(id, 1'b1, data, inv);
      wait_accept(id, tag, ok);
      drive_req(id, 1'b0, data, inv);
      lat = 0; bad_a = 0; bad_s = 0;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            lat = n;
         end else begin
            nib = (data >> (4 * (n - 1))) & 32'hF;
            if ({28'd0, xu_a} !== nib) bad_a++;
            if (xu_s !== inv) bad_s++;
         end
      end
      check({tag, "_latency"}, lat, 32'd9);
      check({tag, "_xu_a_seq_errs"}, bad_a, 32'd0);
      check({tag, "_xu_s_errs"}, bad_s, 32'd0);
      check({tag, "_res_data"}, bus.res_data, exp_data);
      check({tag, "_res_id"}, {31'd0, bus.res_id}, {31'd0, id});
      check({tag, "_res_parity"}, {31'd0, bus.res_parity}, {31'd0, exp_par(exp_data)});
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int grants[4];
      int g;
      int bad;
      logic [31:0] snap;
      logic [31:0] d;
      logic        inv;
      logic        id;

      tbl[0] = '{1'b0, 32'h1234_5678, 1'b1, 32'hEDCB_A987};
      tbl[1] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
      tbl[2] = '{1'b0, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE};
      tbl[3] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
      tbl[4] = '{1'b1, 32'hA5A5_5A5A, 1'b1, 32'h5A5A_A5A5};
      tbl[5] = '{1'b0, 32'h0F0F_F0F0, 1'b0, 32'h0F0F_F0F0};

      rst = 1'b1;
      bus.res_ready = 1'b1;
      drive_req(1'b0, 1'b0, 32'd0, 1'b0);
      drive_req(1'b1, 1'b0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("rst_res_data", bus.res_data, 32'd0);
      check("rst_res_id", {31'd0, bus.res_id}, 32'd0);
      check("rst_res_parity", {31'd0, bus.res_parity}, 32'd0);
      check("rst_xu_a", {28'd0, xu_a}, 32'd0);
      check("rst_xu_s", {31'd0, xu_s}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         do_op(tbl[i].id, tbl[i].data, tbl[i].inv, tbl[i].exp_data, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 4; i++) begin
         d   = $urandom;
         inv = 1'($urandom_range(0, 1));
         id  = 1'($urandom_range(0, 1));
         do_op(id, d, inv, d ^ {32{inv}}, $sformatf("rnd%0d", i));
      end

      // Both requesters valid continuously from reset: grants must alternate starting with req0.
      @(posedge clk); #1;
      rst = 1'b1;
      drive_req(1'b0, 1'b1, 32'h1111_2222, 1'b0);
      drive_req(1'b1, 1'b1, 32'h3333_4444, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      g = 0;
      for (int n = 0; n < 80 && g < 4; n++) begin
         @(negedge clk);
         if (bus.req0_valid && bus.req0_ready) begin grants[g] = 0; g++; end
         else if (bus.req1_valid && bus.req1_ready) begin grants[g] = 1; g++; end
         if (g == 4) begin
            @(posedge clk); #1;
            drive_req(1'b0, 1'b0, 32'd0, 1'b0);
            drive_req(1'b1, 1'b0, 32'd0, 1'b0);
         end
      end
      check("arb_grant_count", g, 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("arb_grant%0d", i), grants[i], i % 2);
      for (int n = 0; n < 30 && sb_q.size() != 0; n++) @(negedge clk);
      check("arb_drain", sb_q.size(), 32'd0);

      // Consumer stalls for five DONE cycles; result must hold and requesters stay blocked.
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      drive_req(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
      wait_accept(1'b0, "stall", ok);
      drive_req(1'b0, 1'b0, 32'd0, 1'b0);
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         ok = bus.res_valid;
      end
      check("stall_res_valid_rise", {31'd0, ok}, 32'd1);
      snap = bus.res_data;
      check("stall_res_data", snap, 32'h3501_0FF2);
      bad = 0;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) @(negedge clk);
         if (!bus.res_valid || bus.res_data !== snap || bus.req0_ready || bus.req1_ready) bad++;
         if (k == 1) begin
            @(posedge clk); #1;
            drive_req(1'b0, 1'b1, 32'h5555_0000, 1'b0);
            drive_req(1'b1, 1'b1, 32'h0000_5555, 1'b0);
         end
      end
      check("stall_hold_errs", bad, 32'd0);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, 32'd0, 1'b0);
      drive_req(1'b1, 1'b0, 32'd0, 1'b0);
      bus.res_ready = 1'b1;
      @(negedge clk);
      check("stall_6th_valid", {31'd0, bus.res_valid}, 32'd1);
      @(negedge clk);
      check("stall_released", {31'd0, bus.res_valid}, 32'd0);

      // Reset in the middle of RUN discards the operand.
      @(posedge clk); #1;
      drive_req(1'b0, 1'b1, 32'h8765_4321, 1'b0);
      wait_accept(1'b0, "midrst", ok);
      drive_req(1'b0, 1'b0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_xu_a_idx3", {28'd0, xu_a}, 32'h4);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("midrst_xu_a", {28'd0, xu_a}, 32'd0);
      check("midrst_xu_s", {31'd0, xu_s}, 32'd0);
      check("midrst_res_data", bus.res_data, 32'd0);
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.res_valid) bad++;
      end
      check("midrst_no_result", bad, 32'd0);

      do_op(1'b1, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, "post_rst");

      check("sb_empty", sb_q.size(), 32'd0);
      check("never_two_ready", two_ready_cnt, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
